// File: rtl/xc_uart_rx.sv
// 8N1 UART receiver with a 2-flop synchroniser, 3-sample majority vote and a valid/ready byte output.
// Define XC_UART_PARITY_EN to receive 8E1 frames and drive parity_err.
module xc_uart_rx #(
  parameter int unsigned CLK_FREQUENCY = 13300000,
  parameter int unsigned BAUD_RATE     = 57600,
  parameter int unsigned BIT_TICKS     = CLK_FREQUENCY / BAUD_RATE
) (
  input  logic       clki,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned CW   = $clog2(BIT_TICKS);
  localparam int unsigned HALF = BIT_TICKS / 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
  localparam logic [CW-1:0] CNT_DEC  = CW'(HALF + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
`ifdef XC_UART_PARITY_EN
  localparam logic [2:0] PARITY    = 3'd3;
`endif
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_HIGH = 3'd5;

  if (BIT_TICKS < 8) begin : g_bit_ticks_check
    $error("xc_uart_rx: BIT_TICKS must be at least 8");
  end

  logic          rx_m, rx_s, rx_d;
  logic [2:0]    state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    idx, idx_next;
  logic [7:0]    shreg, shreg_next;
  logic          smp0, smp1;
  logic          maj, wrap, decide;
  logic [7:0]    dout_next;
  logic          dvalid_next, ferr_next, oerr_next, perr_next;
`ifdef XC_UART_PARITY_EN
  logic          par_bad, par_bad_next;
`endif

  assign maj    = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
  assign wrap   = (cnt == CNT_LAST);
  assign decide = (cnt == CNT_DEC);

  // Next-state, counter, shifter and output decode
  always_comb begin
    state_next  = state;
    cnt_next    = wrap ? '0 : cnt + CW'(1);
    idx_next    = idx;
    shreg_next  = shreg;
    dout_next   = data_out;
    dvalid_next = data_valid & ~data_ready;
    ferr_next   = 1'b0;
    oerr_next   = 1'b0;
    perr_next   = 1'b0;
`ifdef XC_UART_PARITY_EN
    par_bad_next = par_bad;
`endif
    case (state)
      IDLE: begin
        cnt_next = '0;
`ifdef XC_UART_PARITY_EN
        par_bad_next = 1'b0;
`endif
        if (rx_d && !rx_s) state_next = START;
      end
      START: begin
        if (decide && maj) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (wrap) begin
          state_next = DATA;
          idx_next   = 3'd0;
        end
      end
      DATA: begin
        if (decide) shreg_next = {maj, shreg[7:1]};
        if (wrap) begin
          idx_next = idx + 3'd1;
`ifdef XC_UART_PARITY_EN
          if (idx == 3'd7) state_next = PARITY;
`else
          if (idx == 3'd7) state_next = STOP;
`endif
        end
      end
`ifdef XC_UART_PARITY_EN
      PARITY: begin
        if (decide) par_bad_next = maj ^ (^shreg);
        if (wrap) state_next = STOP;
      end
`endif
      STOP: begin
        // Decide at mid-stop so a back-to-back start edge is not missed
        if (decide) begin
`ifdef XC_UART_PARITY_EN
          perr_next = par_bad;
`endif
          if (maj) begin
            state_next = IDLE;
            if (!data_valid || data_ready) begin
              dout_next   = shreg;
              dvalid_next = 1'b1;
            end else begin
              oerr_next = 1'b1;
            end
          end else begin
            ferr_next  = 1'b1;
            state_next = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      rx_d        <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      idx         <= 3'd0;
      shreg       <= 8'd0;
      smp0        <= 1'b1;
      smp1        <= 1'b1;
      data_out    <= 8'd0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      parity_err  <= 1'b0;
      busy        <= 1'b0;
`ifdef XC_UART_PARITY_EN
      par_bad     <= 1'b0;
`endif
    end else begin
      rx_m        <= rx;
      rx_s        <= rx_m;
      rx_d        <= rx_s;
      state       <= state_next;
      cnt         <= cnt_next;
      idx         <= idx_next;
      shreg       <= shreg_next;
      if (cnt == CNT_S0) smp0 <= rx_s;
      if (cnt == CNT_S1) smp1 <= rx_s;
      data_out    <= dout_next;
      data_valid  <= dvalid_next;
      frame_err   <= ferr_next;
      overrun_err <= oerr_next;
      parity_err  <= perr_next;
      busy        <= (state_next != IDLE);
`ifdef XC_UART_PARITY_EN
      par_bad     <= par_bad_next;
`endif
    end
  end

endmodule

// File: tb/tb_xc_uart_rx.sv
// Directed bench for xc_uart_rx at default clock/baud; honours XC_UART_PARITY_EN.
module tb_xc_uart_rx;

  localparam int unsigned BT   = 13300000 / 57600;
  localparam int unsigned HALF = BT / 2;
`ifdef XC_UART_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif
  localparam int unsigned PADD   = PARITY_ON ? BT : 0;
  localparam int unsigned LAT_LO = 2189 + PADD;
  localparam int unsigned LAT_HI = 2192 + PADD;

  logic       clki = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       data_ready;
  logic [7:0] data_out;
  logic       data_valid, frame_err, overrun_err, parity_err, busy;

  always #5 clki = ~clki;

  xc_uart_rx dut (
    .clki        (clki),
    .rst_n       (rst_n),
    .rx          (rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err),
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;
  int ferr_n = 0, oerr_n = 0, perr_n = 0, acc_n = 0;
  logic [7:0] last_byte = 8'd0;

  // Pulse and accept counters sampled mid-cycle
  always @(negedge clki) begin
    if (frame_err)   ferr_n <= ferr_n + 1;
    if (overrun_err) oerr_n <= oerr_n + 1;
    if (parity_err)  perr_n <= perr_n + 1;
    if (data_valid && data_ready) begin
      acc_n     <= acc_n + 1;
      last_byte <= data_out;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BT) @(negedge clki);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic pflip, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    if (PARITY_ON) send_bit((^b) ^ pflip);
    send_bit(stop);
  endtask

  initial begin
    #(10 * 100000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, t, f0, o0, a0;
    rx = 1'b1;
    data_ready = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(negedge clki);
    check_eq("rst_data_valid", 32'(data_valid), 32'd0);
    check_eq("rst_data_out", 32'(data_out), 32'd0);
    check_eq("rst_frame_err", 32'(frame_err), 32'd0);
    check_eq("rst_overrun_err", 32'(overrun_err), 32'd0);
    check_eq("rst_parity_err", 32'(parity_err), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clki);

    // 0xA5 with ready held high: latency, single-cycle valid, clean flags
    f0 = ferr_n; o0 = oerr_n; a0 = acc_n;
    fork
      send_frame(8'hA5, 1'b0, 1'b1);
      begin
        lat = 0;
        while (!data_valid && lat < 4000) begin
          @(posedge clki); #1;
          lat++;
        end
        check_eq("a5_latency", (lat >= LAT_LO && lat <= LAT_HI) ? 32'(LAT_LO) : 32'(lat), 32'(LAT_LO));
        check_eq("a5_data_out", 32'(data_out), 32'hA5);
        check_eq("a5_frame_err", 32'(frame_err), 32'd0);
        check_eq("a5_overrun_err", 32'(overrun_err), 32'd0);
        check_eq("a5_parity_err", 32'(parity_err), 32'd0);
        check_eq("a5_busy_low", 32'(busy), 32'd0);
        @(posedge clki); #1;
        check_eq("a5_valid_one_cycle", 32'(data_valid), 32'd0);
      end
    join
    check_eq("a5_accepts", 32'(acc_n - a0), 32'd1);
    check_eq("a5_no_ferr", 32'(ferr_n - f0), 32'd0);
    check_eq("a5_no_oerr", 32'(oerr_n - o0), 32'd0);
    repeat (BT) @(negedge clki);

    // 40-clock glitch is rejected at the start-bit decision
    f0 = ferr_n; a0 = acc_n;
    fork
      begin
        rx = 1'b0;
        repeat (40) @(negedge clki);
        rx = 1'b1;
      end
      begin
        t = 0;
        while (!busy && t < 20) begin
          @(posedge clki); #1;
          t++;
        end
        check_eq("glitch_busy_rise", 32'(busy), 32'd1);
        n = 0;
        while (busy && n < 1000) begin
          @(posedge clki); #1;
          n++;
        end
        check_eq("glitch_busy_fall", (n <= HALF + 3) ? 32'(HALF + 3) : 32'(n), 32'(HALF + 3));
      end
    join
    repeat (2 * BT) @(negedge clki);
    check_eq("glitch_no_valid", 32'(acc_n - a0), 32'd0);
    check_eq("glitch_no_ferr", 32'(ferr_n - f0), 32'd0);

    // 0x3C with low stop bit, then a held break: one frame_err, then 0x55
    f0 = ferr_n; a0 = acc_n;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (5 * BT) @(negedge clki);
    check_eq("break_busy_held", 32'(busy), 32'd1);
    check_eq("break_one_ferr", 32'(ferr_n - f0), 32'd1);
    rx = 1'b1;
    repeat (5) @(negedge clki);
    check_eq("break_release_idle", 32'(busy), 32'd0);
    check_eq("break_ferr_still_one", 32'(ferr_n - f0), 32'd1);
    check_eq("break_no_valid", 32'(acc_n - a0), 32'd0);
    repeat (BT) @(negedge clki);
    send_frame(8'h55, 1'b0, 1'b1);
    check_eq("after_break_byte", 32'(last_byte), 32'h55);
    check_eq("after_break_accepts", 32'(acc_n - a0), 32'd1);
    check_eq("after_break_ferr", 32'(ferr_n - f0), 32'd1);

    // Back-to-back 0x11, 0x22 with ready low: overrun keeps the first byte
    @(posedge clki); #1 data_ready = 1'b0;
    f0 = ferr_n; o0 = oerr_n; a0 = acc_n;
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    check_eq("ovr_valid_held", 32'(data_valid), 32'd1);
    check_eq("ovr_data_kept", 32'(data_out), 32'h11);
    check_eq("ovr_one_pulse", 32'(oerr_n - o0), 32'd1);
    check_eq("ovr_no_ferr", 32'(ferr_n - f0), 32'd0);
    check_eq("ovr_no_accept", 32'(acc_n - a0), 32'd0);
    @(posedge clki); #1 data_ready = 1'b1;
    @(posedge clki); #1;
    check_eq("ovr_valid_cleared", 32'(data_valid), 32'd0);
    check_eq("ovr_accepted_byte", 32'(last_byte), 32'h11);
    check_eq("ovr_accept_count", 32'(acc_n - a0), 32'd1);
    repeat (BT) @(negedge clki);

    // Reset asserted mid data bit 4 of 0xF0, then 0x0F
    f0 = ferr_n; o0 = oerr_n; a0 = acc_n;
    fork
      send_frame(8'hF0, 1'b1, 1'b1);
      begin
        repeat (5 * BT + HALF) @(negedge clki);
        check_eq("mid_frame_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_data_valid", 32'(data_valid), 32'd0);
        check_eq("midrst_data_out", 32'(data_out), 32'd0);
        check_eq("midrst_frame_err", 32'(frame_err), 32'd0);
        repeat (3) @(negedge clki);
        rst_n = 1'b1;
      end
    join
    repeat (BT) @(negedge clki);
    check_eq("midrst_no_ferr", 32'(ferr_n - f0), 32'd0);
    check_eq("midrst_no_oerr", 32'(oerr_n - o0), 32'd0);
    check_eq("midrst_no_accept", 32'(acc_n - a0), 32'd0);
    send_frame(8'h0F, 1'b0, 1'b1);
    check_eq("post_rst_byte", 32'(last_byte), 32'h0F);
    check_eq("post_rst_accepts", 32'(acc_n - a0), 32'd1);

`ifdef XC_UART_PARITY_EN
    // 0x03 with parity bit 1: parity_err alongside the delivered byte
    repeat (BT) @(negedge clki);
    fork
      send_frame(8'h03, 1'b1, 1'b1);
      begin
        lat = 0;
        while (!data_valid && lat < 4000) begin
          @(posedge clki); #1;
          lat++;
        end
        check_eq("par_valid", 32'(data_valid), 32'd1);
        check_eq("par_err_with_valid", 32'(parity_err), 32'd1);
        check_eq("par_data_out", 32'(data_out), 32'h03);
      end
    join
`endif

    repeat (BT) @(negedge clki);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
